alu_host_sequencer: RTL and testbench
=====================================

# alu_host_sequencer

Host-side master for the ALU control unit's BEGIN/END protocol. Accepts one operation request over a valid/ready handshake, starts the ALU, supplies operands on INBUS in the cycles the ALU's load strobes request them, and captures A/Q from OUTBUS as the ALU pushes them. It returns a packed result over a second valid/ready handshake. Sits between the system-side command source and the ALU datapath plus control unit.

## Interface
Parameters:
- W, 8: operand/register width (INBUS, OUTBUS, A, Q, M).
- TIMEOUT, 255: max cycles in RUN without alu_end before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_x  in  W  first operand / multiplicand / dividend.
- req_y  in  W  second operand / multiplier / divisor.
- res_valid  out  1  result held in DONE.
- res_ready  in  1  result consumed.
- res_hi  out  W  A register (product high, remainder); 0 for add/sub.
- res_lo  out  W  Q register (product low, quotient); A for add/sub.
- res_err  out  1  result produced by timeout abort.
- alu_begin  out  1  one-cycle start pulse to the ALU.
- alu_op_code  out  2  registered op, stable from START through DONE.
- alu_inbus  out  W  operand bus to the ALU.
- alu_load_a, alu_load_q, alu_load_m  in  1 each  ALU samples INBUS into A/Q/M at this edge.
- alu_push_a, alu_push_q  in  1 each  ALU drives A/Q onto OUTBUS the following cycle.
- alu_outbus  in  W  ALU output bus.
- alu_end  in  1  ALU returning to idle.

## Operation
- FSM states are IDLE, START, RUN and DONE.
- IDLE: req_ready=1. On req_valid, latch op/x/y and go to START.
- START: alu_begin=1 for exactly one cycle, then go to RUN.
- RUN:
  - alu_inbus is combinational from the strobes (priority A > Q > M); 0 when no strobe is high.
  - Operand map: add/sub A=x, M=y. Mul Q=x, M=y (the ALU zeroes A). Div A=0, Q=x, M=y.
  - push_a/push_q are registered one cycle (push_d). While push_d is high, alu_outbus is written into res_hi (A) or res_lo (Q).
  - Add/sub: the captured A value is written into res_lo, and res_hi=0.
  - On alu_end, go to DONE.
- DONE: res_valid=1. On res_ready, go to IDLE. The final push_d capture completes on the END cycle, so results are stable when res_valid rises.
- Load or push strobes outside RUN are ignored.
- A duplicate push for the same register overwrites the earlier capture (last wins).

## Timing
- Reset values: all outputs 0 except req_ready=1. State=IDLE. Result registers and the timeout counter are 0.
- Request accept to alu_begin: 1 cycle. alu_begin to the first inbus use follows ALU timing; alu_inbus has 0 added latency.
- alu_end to res_valid: 1 cycle.
- A new req_valid during START, RUN or DONE is not accepted (req_ready=0).
- Simultaneous res_ready and a new req_valid in DONE: the request is accepted on the following IDLE cycle, not the same cycle.
- Reset mid-operation: IDLE on the next edge, any result is dropped, and alu_begin is not reissued.

## Configuration
- ALU_HOST_TIMEOUT_EN defined:
  - The counter runs in RUN and clears on entry to RUN.
  - When it reaches TIMEOUT without alu_end, go to DONE with res_err=1 and results as captured so far.
  - res_err clears when leaving DONE.
- Undefined: no counter is implemented, res_err is tied 0, and RUN waits indefinitely for alu_end.

## Structure
- Shared package alu_pkg holds the op-code localparams (OP_ADD/SUB/MUL/DIV) and the host state encoding enum; the control unit uses the same op constants.
- One natural sub-module: alu_host_watchdog (counter plus compare), instantiated only under ALU_HOST_TIMEOUT_EN.

## Test plan
- Add x=8'h25, y=8'h13 with the ALU model:
  - alu_inbus=25 on load_a and 13 on load_m.
  - res_lo=8'h38, res_hi=0, res_err=0.
- Mul x=8'd12, y=8'd11:
  - inbus 12 on load_q, 11 on load_m.
  - Result {res_hi,res_lo}=16'd132.
- Div x=8'd100, y=8'd7:
  - inbus 0, 100, 7 on load_a, load_q, load_m.
  - res_lo=14, res_hi=2.
- res_ready held 0 for 5 cycles after res_valid: results and res_valid remain stable, req_ready=0, and a concurrent req_valid is ignored.
- Model never asserts alu_end, TIMEOUT=20:
  - With the macro: res_valid and res_err rise at 20 cycles after RUN entry.
  - Without the macro: FSM stays in RUN.
- reset pulsed during RUN: the next cycle shows req_ready=1, res_valid=0 and alu_begin=0. A fresh sub 9-4 then gives res_lo=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants used by the host sequencer and the
// ALU control unit, plus the host sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } host_state_t;

  // Add and subtract share one operand map and return A as the low result.
  function automatic logic is_addsub(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_host_watchdog.sv
// Run-time watchdog for the host sequencer.
// Ports: clk, reset (sync, active-high), run (sequencer is in RUN),
//        expired_c (combinational: this RUN cycle completes TIMEOUT cycles).
module alu_host_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Held at zero outside RUN, so every RUN entry starts from a cleared count.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign expired_c = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_host_sequencer.sv
// Host-side master for the ALU BEGIN/END protocol: accepts one request, starts
// the ALU, feeds operands on the load strobes, captures A/Q pushes and returns
// a result over a valid/ready handshake.
// Ports: clk, reset (sync, active-high); req_* request handshake and operands;
//        res_* result handshake, result registers and timeout flag;
//        alu_* ALU control/data interface (alu_inbus is combinational).
// Optional build macro: ALU_HOST_TIMEOUT_EN adds the RUN watchdog and res_err.
module alu_host_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_x,
  input  logic [W-1:0] req_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic         res_err,
  output logic         alu_begin,
  output logic [1:0]   alu_op_code,
  output logic [W-1:0] alu_inbus,
  input  logic         alu_load_a,
  input  logic         alu_load_q,
  input  logic         alu_load_m,
  input  logic         alu_push_a,
  input  logic         alu_push_q,
  input  logic [W-1:0] alu_outbus,
  input  logic         alu_end
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_host_sequencer: TIMEOUT must be at least 1");
  end

  host_state_t  state_q, state_d;
  logic [W-1:0] x_q, y_q;
  logic         push_a_d, push_q_d;
  logic         timeout_c;
  logic         in_run_c;

  assign in_run_c = (state_q == ST_RUN);

`ifdef ALU_HOST_TIMEOUT_EN
  logic res_err_q;

  alu_host_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .run      (in_run_c),
    .expired_c(timeout_c)
  );

  // Set on a watchdog abort, cleared as soon as the sequencer leaves DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_err_q <= 1'b0;
    end else if (in_run_c && !alu_end && timeout_c) begin
      res_err_q <= 1'b1;
    end else if (state_d != ST_DONE) begin
      res_err_q <= 1'b0;
    end
  end

  assign res_err = res_err_q;
`else
  assign timeout_c = 1'b0;
  assign res_err   = 1'b0;
`endif

  // Next-state logic; alu_end takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (alu_end || timeout_c) state_d = ST_DONE;
      end
      ST_DONE:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and handshake/control outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b1;
      alu_begin <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_IDLE);
      alu_begin <= (state_d == ST_START);
      res_valid <= (state_d == ST_DONE);
    end
  end

  // Request latch; results are cleared so an abort reports only this op's captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op_code <= OP_ADD;
      x_q         <= '0;
      y_q         <= '0;
      push_a_d    <= 1'b0;
      push_q_d    <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
    end else begin
      push_a_d <= in_run_c && alu_push_a;
      push_q_d <= in_run_c && alu_push_q;
      if (state_q == ST_IDLE && req_valid) begin
        alu_op_code <= req_op;
        x_q         <= req_x;
        y_q         <= req_y;
        res_hi      <= '0;
        res_lo      <= '0;
      end else if (in_run_c) begin
        // Add/sub report A in the low half; a later push of the same register wins.
        if (push_a_d) begin
          if (is_addsub(alu_op_code)) res_lo <= alu_outbus;
          else                        res_hi <= alu_outbus;
        end
        if (push_q_d && !is_addsub(alu_op_code)) begin
          res_lo <= alu_outbus;
        end
      end
    end
  end

  // Operand bus follows the load strobes with no added latency (A > Q > M).
  always_comb begin
    alu_inbus = '0;
    if (in_run_c) begin
      if (alu_load_a) begin
        alu_inbus = is_addsub(alu_op_code) ? x_q : '0;
      end else if (alu_load_q) begin
        alu_inbus = is_addsub(alu_op_code) ? '0 : x_q;
      end else if (alu_load_m) begin
        alu_inbus = y_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_host_sequencer.sv
module tb_alu_host_sequencer;

  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_x, req_y;
  logic         res_valid, res_ready;
  logic [W-1:0] res_hi, res_lo;
  logic         res_err;
  logic         alu_begin;
  logic [1:0]   alu_op_code;
  logic [W-1:0] alu_inbus;
  logic         alu_load_a, alu_load_q, alu_load_m;
  logic         alu_push_a, alu_push_q;
  logic [W-1:0] alu_outbus;
  logic         alu_end;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] in_a, in_q, in_m;

  alu_host_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err),
    .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
    .alu_load_a(alu_load_a), .alu_load_q(alu_load_q), .alu_load_m(alu_load_m),
    .alu_push_a(alu_push_a), .alu_push_q(alu_push_q),
    .alu_outbus(alu_outbus), .alu_end(alu_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; it is taken on the next rising edge.
  task automatic send_req(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
  endtask

  // Wait (bounded) for the START cycle, then withdraw the request.
  task automatic wait_begin(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (alu_begin === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check(tag, 32'(seen), 32'd1);
  endtask

  // Behavioural ALU: called in the START cycle, returns in the first DONE cycle.
  task automatic alu_model(input logic [1:0] op);
    logic [W-1:0]   a, q, m;
    logic [2*W-1:0] p;
    bit             addsub;
    addsub = (op == 2'b00) || (op == 2'b01);
    a = '0; q = '0; m = '0;
    in_a = 'x; in_q = 'x; in_m = 'x;
    @(negedge clk);
    if (addsub || op == 2'b11) begin
      alu_load_a = 1'b1; #1 a = alu_inbus; in_a = a;
      @(negedge clk); alu_load_a = 1'b0;
    end
    if (!addsub) begin
      alu_load_q = 1'b1; #1 q = alu_inbus; in_q = q;
      @(negedge clk); alu_load_q = 1'b0;
    end
    alu_load_m = 1'b1; #1 m = alu_inbus; in_m = m;
    @(negedge clk); alu_load_m = 1'b0;
    case (op)
      2'b00: a = a + m;
      2'b01: a = a - m;
      2'b10: begin p = q * m; a = p[2*W-1:W]; q = p[W-1:0]; end
      default: begin
        a = (m == 0) ? '0 : q % m;
        q = (m == 0) ? '0 : q / m;
      end
    endcase
    alu_push_a = 1'b1;
    @(negedge clk);
    alu_push_a = 1'b0;
    alu_outbus = a;
    if (addsub) begin
      alu_end = 1'b1;
    end else begin
      alu_push_q = 1'b1;
      @(negedge clk);
      alu_push_q = 1'b0;
      alu_outbus = q;
      alu_end    = 1'b1;
    end
    @(negedge clk);
    alu_end    = 1'b0;
    alu_outbus = '0;
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_x = '0; req_y = '0;
    res_ready = 1'b0; alu_load_a = 1'b0; alu_load_q = 1'b0; alu_load_m = 1'b0;
    alu_push_a = 1'b0; alu_push_q = 1'b0; alu_outbus = '0; alu_end = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_begin", 32'(alu_begin), 32'd0);
    check("rst_res_err",   32'(res_err),   32'd0);
    check("rst_result",    32'({res_hi, res_lo}), 32'd0);
    check("rst_op_code",   32'(alu_op_code), 32'd0);
    check("rst_inbus",     32'(alu_inbus), 32'd0);

    // Add 0x25 + 0x13
    send_req(2'b00, 8'h25, 8'h13);
    wait_begin("add_begin");
    check("add_req_ready", 32'(req_ready), 32'd0);
    alu_model(2'b00);
    check("add_inbus_a", 32'(in_a), 32'h25);
    check("add_inbus_m", 32'(in_m), 32'h13);
    check("add_res_valid", 32'(res_valid), 32'd1);
    check("add_res_lo", 32'(res_lo), 32'h38);
    check("add_res_hi", 32'(res_hi), 32'h00);
    check("add_res_err", 32'(res_err), 32'd0);
    release_result("add");

    // Div 100 / 7
    send_req(2'b11, 8'd100, 8'd7);
    wait_begin("div_begin");
    alu_model(2'b11);
    check("div_inbus_a", 32'(in_a), 32'd0);
    check("div_inbus_q", 32'(in_q), 32'd100);
    check("div_inbus_m", 32'(in_m), 32'd7);
    check("div_op_code", 32'(alu_op_code), 32'd3);
    check("div_res_lo", 32'(res_lo), 32'd14);
    check("div_res_hi", 32'(res_hi), 32'd2);
    release_result("div");

    // Mul 12 * 11, then hold the result while a new request waits
    send_req(2'b10, 8'd12, 8'd11);
    wait_begin("mul_begin");
    alu_model(2'b10);
    check("mul_inbus_q", 32'(in_q), 32'd12);
    check("mul_inbus_m", 32'(in_m), 32'd11);
    check("mul_product", 32'({res_hi, res_lo}), 32'd132);
    send_req(2'b00, 8'd1, 8'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_product", 32'({res_hi, res_lo}), 32'd132);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_alu_begin", 32'(alu_begin), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("handoff_req_ready", 32'(req_ready), 32'd1);
    check("handoff_alu_begin", 32'(alu_begin), 32'd0);
    wait_begin("handoff_begin");
    alu_model(2'b00);
    check("handoff_res_lo", 32'(res_lo), 32'd3);
    release_result("handoff");

    // ALU never ends
    send_req(2'b00, 8'h11, 8'h22);
    wait_begin("tmo_begin");
    for (int j = 1; j <= 20; j++) @(negedge clk);
    check("tmo_pre_valid", 32'(res_valid), 32'd0);
    check("tmo_pre_err", 32'(res_err), 32'd0);
    @(negedge clk);
`ifdef ALU_HOST_TIMEOUT_EN
    check("tmo_res_valid", 32'(res_valid), 32'd1);
    check("tmo_res_err", 32'(res_err), 32'd1);
    check("tmo_result", 32'({res_hi, res_lo}), 32'd0);
    release_result("tmo");
    check("tmo_err_cleared", 32'(res_err), 32'd0);
`else
    check("tmo_still_run", 32'(res_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("tmo_late_valid", 32'(res_valid), 32'd0);
    check("tmo_late_ready", 32'(req_ready), 32'd0);
    check("tmo_res_err", 32'(res_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("tmo_recover_ready", 32'(req_ready), 32'd1);
`endif

    // Reset during RUN, then a fresh subtract
    send_req(2'b01, 8'd9, 8'd4);
    wait_begin("rstrun_begin");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstrun_req_ready", 32'(req_ready), 32'd1);
    check("rstrun_res_valid", 32'(res_valid), 32'd0);
    check("rstrun_alu_begin", 32'(alu_begin), 32'd0);
    @(negedge clk);
    check("rstrun_no_rebegin", 32'(alu_begin), 32'd0);
    send_req(2'b01, 8'd9, 8'd4);
    wait_begin("sub_begin");
    alu_model(2'b01);
    check("sub_inbus_a", 32'(in_a), 32'd9);
    check("sub_inbus_m", 32'(in_m), 32'd4);
    check("sub_res_valid", 32'(res_valid), 32'd1);
    check("sub_res_lo", 32'(res_lo), 32'd5);
    check("sub_res_hi", 32'(res_hi), 32'd0);
    release_result("sub");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
